uart_tx: RTL and testbench
==========================

# uart_tx

Top-level UART transmitter, the transmit counterpart of the UART receiver in the uart_echo design. It accepts one byte at a time over a valid/ready handshake and serializes it onto the TXD pin as an 8N1 frame: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit. It contains its own x16 baud-enable counter and a framing state machine, and sits between the echo/character logic and the TXD pad.

## Interface
- BAUD_RATE, 9_600, serial bit rate in bits/s
- CLOCK_RATE, 40_000_000, clk_tx frequency in Hz
- DIVIDER (localparam), round(CLOCK_RATE / (16*BAUD_RATE)), clk_tx cycles per x16 enable; default 260; must be >= 2
- clk_tx  in  1  transmit clock; one clock domain, no other clocks
- rst_clk_tx  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send; sampled only on handshake
- tx_data_valid  in  1  tx_data holds a byte to send
- tx_data_ready  out  1  block can accept a byte this cycle
- txd_tx  out  1  serial output to the TXD pad; idle/mark = 1
- tx_busy  out  1  a frame is in progress

## Operation
- Baud enable: a 9-bit counter (width is ceil(log2(DIVIDER))) counts 0..DIVIDER-1 and wraps. baud_x16_en pulses for one cycle when the count equals DIVIDER-1.
- The counter is cleared to 0 on handshake acceptance, so every frame is phase-aligned to its start.
- FSM states: IDLE, START, DATA, STOP.
- Handshake: a transfer occurs on a rising edge where tx_data_valid && tx_data_ready.
  - On transfer, tx_data is latched into an 8-bit shift register and the FSM moves to START.
  - tx_data_valid while not ready is ignored. The input byte is not sampled and no error is flagged.
- A 4-bit sub-bit counter counts baud enables. A bit ends on the 16th enable of that bit.
- START: txd_tx = 0 for one bit, then go to DATA with the bit index set to 0.
- DATA: txd_tx = shift[0]. At each bit end, shift right and increment the 3-bit index. After index 7 ends, go to STOP.
- STOP: txd_tx = 1 for one bit, then go to IDLE.
- Outputs, all registered:
  - tx_data_ready = (state == IDLE)
  - tx_busy = (state != IDLE)
  - txd_tx = 1 in IDLE and STOP
- Reset (asynchronous; applies immediately, including mid-frame):
  - State goes to IDLE; txd_tx = 1, tx_data_ready = 1, tx_busy = 0.
  - Baud and bit counters are cleared; the shift register is cleared to 0x00.
  - A partially sent frame is abandoned. No resume and no extra stop bit.
- Release of reset is expected to be synchronized externally; the block does not re-synchronize the deassertion edge.

## Timing
- Bit period is exactly 16*DIVIDER clk_tx cycles: 4160 at the defaults.
- Latency: the edge that accepts a byte also drives txd_tx low. txd_tx is low from the cycle after the handshake cycle, and tx_data_ready drops in that same cycle.
- Frame length from the first low cycle to re-entry of IDLE is 10*16*DIVIDER cycles.
- After STOP ends, IDLE lasts at least one cycle with txd_tx = 1 and tx_data_ready = 1.
- Back-to-back: if tx_data_valid is held high, the next byte is accepted in that single IDLE cycle. The effective stop bit is then 16*DIVIDER+1 cycles, and the maximum throughput is one byte per 160*DIVIDER+1 cycles.
- tx_busy rises and falls in the same cycles that tx_data_ready falls and rises.
- No combinational path from any input to any output.

## Test plan
Bench parameters: CLOCK_RATE = 614_400, BAUD_RATE = 9_600, giving DIVIDER = 4 and a bit period of 64 cycles.
- Reset values: assert rst_clk_tx mid-cycle with no clock edge -> txd_tx = 1, tx_data_ready = 1, tx_busy = 0 immediately.
- Single byte: send 0xA5 -> txd_tx low for 64 cycles, then bits 1,0,1,0,0,1,0,1 at 64 cycles each, then high. tx_data_ready = 0 for exactly 640 cycles after the handshake.
- Back-to-back: hold valid with 0x00 then 0xFF -> the two frames are separated by one extra high cycle. 0xFF shows as one low start bit followed by 9 high bits. Exactly 2 handshakes are seen.
- Busy ignore: pulse tx_data_valid with 0x3C at cycle 200 of a 0x81 frame -> the 0x81 frame is unaltered, no second frame follows, and tx_data_ready stays 0 until the frame ends.
- Reset mid-frame: assert reset during data bit 3 of 0x0F -> txd_tx = 1 asynchronously. After release, sending 0x55 yields a clean full frame with its start bit 64 cycles long.
- Loopback: connect txd_tx to uart_rx rxd_i (same parameters) and send 0x00, 0x7E, 0xFF, 0x5A -> uart_rx reports identical rx_data with frm_err = 0 for each byte.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with valid/ready byte input and x16 baud enable.
//   clk_tx        transmit clock
//   rst_clk_tx    asynchronous active-high reset
//   tx_data       byte to send, sampled on handshake
//   tx_data_valid tx_data holds a byte to send
//   tx_data_ready block accepts a byte this cycle (registered, high in IDLE)
//   txd_tx        serial output, idle/mark = 1 (registered)
//   tx_busy       a frame is in progress (registered)
module uart_tx #(
    parameter int BAUD_RATE  = 9_600,
    parameter int CLOCK_RATE = 40_000_000
) (
    input  logic       clk_tx,
    input  logic       rst_clk_tx,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       txd_tx,
    output logic       tx_busy
);
    localparam int DIVIDER = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int CW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [3:0]      sub_q, sub_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            baud_en;
    logic            bit_end;

    always_comb begin
        baud_en = baud_q == CW'(DIVIDER - 1);
        bit_end = baud_en && sub_q == 4'd15;
        baud_d  = baud_en ? '0 : baud_q + 1'b1;
        sub_d   = baud_en ? sub_q + 1'b1 : sub_q;
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: if (tx_data_valid && ready_q) begin
                // Restart the baud and sub-bit counters so the start bit is a full bit long.
                state_d = START;
                shift_d = tx_data;
                baud_d  = '0;
                sub_d   = '0;
            end
            START: if (bit_end) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are computed from the next state so they can be registered without lag.
        txd_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
        ready_d = state_d == IDLE;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
        if (rst_clk_tx) begin
            state_q <= IDLE;
            baud_q  <= '0;
            sub_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_data_ready = ready_q;
    assign txd_tx        = txd_q;
    assign tx_busy       = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at DIVIDER = 4 (64-cycle bit).
module tb_uart_tx;
    localparam int BIT = 64;
    localparam int FRAME = 10 * BIT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         frames = 0;
    int         exp_frames = 0;
    logic       in_frame = 1'b0;

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;
    exp_t exp_q[$];

    uart_tx #(.BAUD_RATE(9_600), .CLOCK_RATE(614_400)) dut (
        .clk_tx(clk),
        .rst_clk_tx(rst),
        .tx_data(tx_data),
        .tx_data_valid(tx_valid),
        .tx_data_ready(tx_ready),
        .txd_tx(txd),
        .tx_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic wait_ready(output logic ok);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = tx_ready === 1'b1;
        if (!ok) chk("ready_timeout", tx_ready, 1);
    endtask

    task automatic send(input logic [7:0] b, output int s);
        logic ok;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        wait_ready(ok);
        s = cyc + 1;
        if (ok) begin
            exp_q.push_back('{b, s});
            exp_frames++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while ((in_frame || tx_ready !== 1'b1 || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("done_timeout", n, 0);
    endtask

    // Monitor: captures each frame from its first low cycle and compares it
    // against the ideal 8N1 waveform built from the expected byte.
    initial begin
        exp_t       e;
        logic [9:0] fb;
        logic [7:0] dec;
        logic       stop_bit, abort, idle_ok;
        int         wave_err, rdy_lo, bsy_hi, st;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                in_frame = 1'b1;
                st = cyc;
                chk("frame_expected", exp_q.size() != 0, 1);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '{8'h00, cyc};
                fb = {1'b1, e.b, 1'b0};
                wave_err = 0; rdy_lo = 0; bsy_hi = 0; dec = 8'h00; stop_bit = 1'b0;
                abort = 1'b0; idle_ok = 1'b0;
                for (int i = 0; i <= FRAME; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                    if (i < FRAME) begin
                        if (txd !== fb[i / BIT]) wave_err++;
                        if (tx_ready === 1'b0) rdy_lo++;
                        if (busy === 1'b1) bsy_hi++;
                        if (i % BIT == BIT / 2 && i / BIT >= 1 && i / BIT <= 8) dec[i / BIT - 1] = txd;
                        if (i == 9 * BIT + BIT / 2) stop_bit = txd;
                    end else begin
                        idle_ok = txd === 1'b1 && tx_ready === 1'b1 && busy === 1'b0;
                    end
                end
                if (!abort) begin
                    frames++;
                    chk("start_cycle", st, e.start);
                    chk("wave_err", wave_err, 0);
                    chk("ready_low_cycles", rdy_lo, FRAME);
                    chk("busy_high_cycles", bsy_hi, FRAME);
                    chk("decoded_byte", dec, e.b);
                    chk("stop_bit", stop_bit, 1);
                    chk("idle_after_frame", idle_ok, 1);
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        int         s, s1, s2, f0;
        logic       ok;
        logic [7:0] lb [4];
        lb = '{8'h00, 8'h7E, 8'hFF, 8'h5A};

        // Reset applied between clock edges must act immediately.
        #3 rst = 1'b1;
        #1;
        chk("rst0_txd", txd, 1);
        chk("rst0_ready", tx_ready, 1);
        chk("rst0_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        send(8'hA5, s);
        wait_done();

        // Back-to-back with valid held high.
        f0 = frames;
        @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        wait_ready(ok);
        s1 = cyc + 1;
        if (ok) begin exp_q.push_back('{8'h00, s1}); exp_frames++; end
        @(negedge clk);
        tx_data = 8'hFF;
        wait_ready(ok);
        s2 = cyc + 1;
        if (ok) begin exp_q.push_back('{8'hFF, s2}); exp_frames++; end
        @(negedge clk);
        tx_valid = 1'b0;
        wait_done();
        chk("b2b_gap", s2 - s1, FRAME + 1);
        chk("b2b_frames", frames - f0, 2);

        // A valid pulse while busy must be ignored.
        f0 = frames;
        send(8'h81, s);
        while (cyc < s + 200) @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_done();
        repeat (300) @(negedge clk);
        chk("busy_ignore_frames", frames - f0, 1);

        // Reset during data bit 3 abandons the frame.
        send(8'h0F, s);
        while (cyc < s + 4 * BIT + 20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_txd", txd, 1);
        chk("rstmid_ready", tx_ready, 1);
        chk("rstmid_busy", busy, 0);
        exp_q.delete();
        exp_frames--;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", tx_ready, 1);
        send(8'h55, s);
        wait_done();

        foreach (lb[k]) send(lb[k], s);
        wait_done();

        for (int k = 0; k < 6; k++) begin
            send(8'($urandom), s);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_done();
        repeat (100) @(negedge clk);

        chk("frames_total", frames, exp_frames);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
